terminal_tx_port: RTL and testbench
===================================

TERMINAL_TX_PORT -- requirements
Module: terminal_tx_port

Interface
REQ-001 SHALL have parameter ROWS, default 4, mesh row count.
REQ-002 SHALL have parameter COLUMNS, default 4, mesh column count.
REQ-003 SHALL have parameter PAKG_SIZE, default 32, packet width in bits (minimum 17).
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, total packet storage including the head entry.
REQ-005 SHALL have parameters MY_ROW and MY_COL, default 0, this terminal's own mesh address.
REQ-006 SHALL have parameter BDCST, default 8'hFF, broadcast identifier placed in the next-jump field.
REQ-007 SHALL have parameter STALL_LIMIT, default 1024, cycles of unserviced pending before a stall flag.
REQ-008 clk  in  1  single clock; all logic on rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 req_valid  in  1  user request to enqueue one packet.
REQ-011 req_ready  out  1  request accepted this cycle when high together with req_valid.
REQ-012 req_row / req_col  in  4 / 4  destination row and column.
REQ-013 req_mode  in  1  routing mode bit; req_bcast  in  1  broadcast request.
REQ-014 req_payload  in  PAKG_SIZE-17  payload bits.
REQ-015 pndng  out  1  head packet valid toward router (drives router pndng_i_in).
REQ-016 data_out  out  PAKG_SIZE  head packet (drives router data_out_i_in).
REQ-017 popin  in  1  router consumes head packet.
REQ-018 count  out  $clog2(FIFO_DEPTH+1)  stored packets; stall  out  1; popin_err  out  1; drop  out  1.

Function
REQ-019 Packet format SHALL be {next_jump[PAKG_SIZE-1 -: 8], row[PAKG_SIZE-9 -: 4], col[PAKG_SIZE-13 -: 4], mode[PAKG_SIZE-17], payload}; next_jump = BDCST if req_bcast, else 8'h00.
REQ-020 req_ready SHALL equal (count < FIFO_DEPTH), independent of popin.
REQ-021 Accepted packet SHALL enter storage on the accepting edge; pndng SHALL rise on the next edge if storage was empty (1-cycle latency).
REQ-022 data_out SHALL be first-word-fall-through: head stable while pndng high and popin low.
REQ-023 popin with pndng high SHALL remove the head on that edge; next entry visible next cycle; pndng falls if none remain.
REQ-024 Simultaneous accept and pop SHALL leave count unchanged, order preserved (FIFO).
REQ-025 popin with pndng low SHALL be ignored and SHALL set popin_err (sticky until reset).
REQ-026 Head FSM states EMPTY, PENDING: EMPTY->PENDING when count becomes nonzero; PENDING->EMPTY when last entry popped.
REQ-027 Stall counter SHALL increment each cycle in PENDING without popin, clear on popin or EMPTY, saturate; stall high while counter >= STALL_LIMIT.
REQ-028 Read/write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-029 reset SHALL clear storage, pointers, count=0, pndng=0, data_out=0, stall=0, popin_err=0, drop=0, FSM=EMPTY; req_ready=1 in the cycle after.
REQ-030 reset mid-operation SHALL discard all stored packets; popin during reset ignored.

Configuration
REQ-031 Macro TX_SELF_DROP_EN defined: non-broadcast requests with row==MY_ROW and col==MY_COL SHALL be accepted (req_ready honoured), not stored, and drop pulses 1 cycle.
REQ-032 TX_SELF_DROP_EN undefined: such requests SHALL be stored normally; drop tied to 0.

Structure
REQ-033 Field offsets, widths and FSM state enum SHALL live in shared package mesh_term_pkg.
REQ-034 Storage SHALL be one sub-module term_tx_fifo (FWFT, parameterised width/depth); FSM, formatting, stall and drop logic in the top.

Verification
REQ-035 Single push row=2,col=3,mode=1,payload=0x5A5A, no bcast -> pndng=1 next cycle, data_out=32'h0023_DA5A... per REQ-019 field packing, count=1.
REQ-036 Push 16 with popin=0 -> req_ready=0 at count=16; 17th request not accepted; pops return packets in order.
REQ-037 Full FIFO, req_valid and popin same cycle -> no accept (ready low), count 16->15; at count=15 simultaneous accept+pop keeps 15.
REQ-038 popin=1 with empty FIFO -> popin_err=1, count stays 0; holds until reset.
REQ-039 One packet, popin held 0 for 1024 cycles -> stall=1 at cycle 1024; single popin -> stall=0 next cycle.
REQ-040 With TX_SELF_DROP_EN, MY_ROW=1,MY_COL=1, request to (1,1) -> drop pulse, count stays 0; same with req_bcast=1 -> stored, next_jump=8'hFF.

Source files
------------

// File: rtl/mesh_term_pkg.sv
// rtl/mesh_term_pkg.sv - packet field layout and head FSM states shared by the mesh terminal blocks
package mesh_term_pkg;

  // Field MSB positions are measured down from PAKG_SIZE (field msb = PAKG_SIZE - *_OFS).
  localparam int NJ_W     = 8;
  localparam int ROW_W    = 4;
  localparam int COL_W    = 4;
  localparam int NJ_OFS   = 1;
  localparam int ROW_OFS  = 9;
  localparam int COL_OFS  = 13;
  localparam int MODE_OFS = 17;
  localparam int HDR_W    = 17;

  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_PENDING = 1'b1
  } tx_state_e;

endpackage

// File: rtl/term_tx_fifo.sv
// rtl/term_tx_fifo.sv - first-word-fall-through packet store with modulo-DEPTH pointers
module term_tx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  // Guards keep the store consistent even if a caller ignores full/empty.
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || pop_i);
  assign do_pop  = pop_i && (count_q != '0);

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ptr_next(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_next(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/terminal_tx_port.sv
// rtl/terminal_tx_port.sv - terminal injection port: packet formatting, head FSM, stall/drop flags
// Optional self-addressed drop is enabled by defining TX_SELF_DROP_EN.
module terminal_tx_port
  import mesh_term_pkg::*;
#(
  parameter int       ROWS        = 4,
  parameter int       COLUMNS     = 4,
  parameter int       PAKG_SIZE   = 32,
  parameter int       FIFO_DEPTH  = 16,
  parameter int       MY_ROW      = 0,
  parameter int       MY_COL      = 0,
  parameter bit [7:0] BDCST       = 8'hFF,
  parameter int       STALL_LIMIT = 1024
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [3:0]                      req_row,
  input  logic [3:0]                      req_col,
  input  logic                            req_mode,
  input  logic                            req_bcast,
  input  logic [PAKG_SIZE-HDR_W-1:0]      req_payload,
  output logic                            pndng,
  output logic [PAKG_SIZE-1:0]            data_out,
  input  logic                            popin,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            stall,
  output logic                            popin_err,
  output logic                            drop
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  logic [PAKG_SIZE-1:0] pkt, head;
  logic                 accept, push, pop;
  tx_state_e            state_q, state_d;
  logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic                 popin_err_q;

  always_comb begin
    pkt = '0;
    pkt[PAKG_SIZE-NJ_OFS -: NJ_W]   = req_bcast ? BDCST : 8'h00;
    pkt[PAKG_SIZE-ROW_OFS -: ROW_W] = req_row;
    pkt[PAKG_SIZE-COL_OFS -: COL_W] = req_col;
    pkt[PAKG_SIZE-MODE_OFS]         = req_mode;
    pkt[PAKG_SIZE-HDR_W-1:0]        = req_payload;
  end

  assign req_ready = (count < CNT_W'(FIFO_DEPTH));
  assign accept    = req_valid && req_ready;
  assign pop       = popin && (state_q == ST_PENDING);

`ifdef TX_SELF_DROP_EN
  logic self_hit, drop_q;
  assign self_hit = !req_bcast && (req_row == 4'(MY_ROW)) && (req_col == 4'(MY_COL));
  assign push     = accept && !self_hit;

  always_ff @(posedge clk) begin
    if (reset) drop_q <= 1'b0;
    else       drop_q <= accept && self_hit;
  end
  assign drop = drop_q;
`else
  assign push = accept;
  assign drop = 1'b0;
`endif

  term_tx_fifo #(.WIDTH(PAKG_SIZE), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (pkt),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count)
  );

  // Next state tracks the store's next occupancy so pndng rises one cycle after the accept.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = '0;
    case (state_q)
      ST_EMPTY:   if (push) state_d = ST_PENDING;
      ST_PENDING: if (pop && !push && (count == CNT_W'(1))) state_d = ST_EMPTY;
      default:    state_d = ST_EMPTY;
    endcase
    if ((state_q == ST_PENDING) && !popin)
      stall_cnt_d = (stall_cnt_q < STALL_W'(STALL_LIMIT)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      stall_cnt_q <= '0;
      popin_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      if (popin && (state_q == ST_EMPTY)) popin_err_q <= 1'b1;
    end
  end

  assign pndng     = (state_q == ST_PENDING);
  assign data_out  = pndng ? head : '0;
  assign stall     = (stall_cnt_q >= STALL_W'(STALL_LIMIT));
  assign popin_err = popin_err_q;

endmodule

// File: tb/tb_terminal_tx_port.sv
// tb/tb_terminal_tx_port.sv - scoreboard bench for terminal_tx_port (MY_ROW=1, MY_COL=1)
module tb_terminal_tx_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [3:0]  req_row, req_col;
  logic        req_mode, req_bcast;
  logic [14:0] req_payload;
  logic        pndng;
  logic [31:0] data_out;
  logic        popin;
  logic [4:0]  count;
  logic        stall, popin_err, drop;

  int checks = 0;
  int errors = 0;
  int mdl_cnt = 0;
  logic [31:0] sb[$];

  terminal_tx_port #(.MY_ROW(1), .MY_COL(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_row(req_row), .req_col(req_col), .req_mode(req_mode), .req_bcast(req_bcast),
    .req_payload(req_payload), .pndng(pndng), .data_out(data_out), .popin(popin),
    .count(count), .stall(stall), .popin_err(popin_err), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic [3:0] r, input logic [3:0] c,
                                       input logic m, input logic b, input logic [14:0] p);
    return {(b ? 8'hFF : 8'h00), r, c, m, p};
  endfunction

  function automatic bit is_self(input logic [3:0] r, input logic [3:0] c, input logic b);
`ifdef TX_SELF_DROP_EN
    return !b && (r == 4'd1) && (c == 4'd1);
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: every consumed head packet must match the oldest expected packet.
  always @(negedge clk) begin
    if (!reset && popin && pndng) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_order: got %0h expected none (scoreboard empty)", data_out);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (data_out !== e) begin
          errors++;
          $display("FAIL pop_order: got %0h expected %0h", data_out, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [3:0] r, input logic [3:0] c,
                       input logic m, input logic b, input logic [14:0] p, input bit pop);
    bit acc, do_pop;
    req_valid = v; req_row = r; req_col = c; req_mode = m; req_bcast = b;
    req_payload = p; popin = pop;
    chk("req_ready", {31'd0, req_ready}, {31'd0, mdl_cnt < 16});
    acc    = v && (mdl_cnt < 16);
    do_pop = pop && (mdl_cnt > 0);
    if (acc && !is_self(r, c, b)) begin
      sb.push_back(pack(r, c, m, b, p));
      mdl_cnt++;
    end
    if (do_pop) mdl_cnt--;
    tick();
  endtask

  task automatic idle();
    req_valid = 1'b0; popin = 1'b0;
    tick();
  endtask

  task automatic do_reset(input bit pop_during);
    reset = 1'b1; req_valid = 1'b0; popin = pop_during;
    tick(); tick();
    reset = 1'b0; popin = 1'b0;
    sb.delete();
    mdl_cnt = 0;
  endtask

  initial begin
    req_valid = 0; req_row = 0; req_col = 0; req_mode = 0; req_bcast = 0;
    req_payload = 0; popin = 0;
    do_reset(1'b0);
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_pndng", {31'd0, pndng}, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_popin_err", {31'd0, popin_err}, 32'd0);
    chk("rst_drop", {31'd0, drop}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Single packet, hand-packed header.
    drive(1, 4'd2, 4'd3, 1'b1, 1'b0, 15'h5A5A, 0);
    req_valid = 1'b0;
    chk("single_pndng", {31'd0, pndng}, 32'd1);
    chk("single_data", data_out, 32'h0023DA5A);
    chk("single_count", {27'd0, count}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 1);
    popin = 1'b0;
    chk("single_drained_pndng", {31'd0, pndng}, 32'd0);
    chk("single_drained_count", {27'd0, count}, 32'd0);

    // Fill to full; the 17th request is refused.
    for (int i = 0; i < 17; i++)
      drive(1, 4'(i), 4'(15 - i), i[0], 1'b0, 15'(16'h1000 + i), 0);
    req_valid = 1'b0;
    chk("full_count", {27'd0, count}, 32'd16);
    chk("full_ready", {31'd0, req_ready}, 32'd0);

    // Full: request plus pop -> only the pop happens; then accept+pop at 15 holds.
    drive(1, 4'd9, 4'd9, 1'b0, 1'b0, 15'h7777, 1);
    chk("full_pop_count", {27'd0, count}, 32'd15);
    drive(1, 4'd5, 4'd6, 1'b1, 1'b0, 15'h2468, 1);
    chk("acc_pop_count", {27'd0, count}, 32'd15);
    for (int i = 0; i < 15; i++) drive(0, 0, 0, 0, 0, 0, 1);
    popin = 1'b0;
    chk("drain_count", {27'd0, count}, 32'd0);
    chk("drain_pndng", {31'd0, pndng}, 32'd0);

    // Pop while empty: sticky error, count unchanged.
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("err_popin_err", {31'd0, popin_err}, 32'd1);
    chk("err_count", {27'd0, count}, 32'd0);
    idle(); idle();
    drive(1, 4'd3, 4'd2, 1'b0, 1'b0, 15'h0101, 0);
    idle();
    chk("err_sticky", {31'd0, popin_err}, 32'd1);

    // Reset mid-operation discards storage and ignores popin.
    drive(1, 4'd4, 4'd4, 1'b0, 1'b0, 15'h0202, 0);
    drive(1, 4'd4, 4'd5, 1'b0, 1'b0, 15'h0303, 0);
    do_reset(1'b1);
    chk("midrst_count", {27'd0, count}, 32'd0);
    chk("midrst_pndng", {31'd0, pndng}, 32'd0);
    chk("midrst_data", data_out, 32'd0);
    chk("midrst_popin_err", {31'd0, popin_err}, 32'd0);
    chk("midrst_ready", {31'd0, req_ready}, 32'd1);

    // Stall after 1024 unserviced pending cycles.
    drive(1, 4'd2, 4'd2, 1'b0, 1'b0, 15'h0ABC, 0);
    req_valid = 1'b0;
    chk("stall_start", {31'd0, stall}, 32'd0);
    for (int i = 0; i < 1023; i++) idle();
    chk("stall_1023", {31'd0, stall}, 32'd0);
    idle();
    chk("stall_1024", {31'd0, stall}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 1);
    popin = 1'b0;
    chk("stall_cleared", {31'd0, stall}, 32'd0);

    // Request addressed to this terminal, then the same as broadcast.
    drive(1, 4'd1, 4'd1, 1'b0, 1'b0, 15'h0055, 0);
    req_valid = 1'b0;
`ifdef TX_SELF_DROP_EN
    chk("self_drop", {31'd0, drop}, 32'd1);
    chk("self_count", {27'd0, count}, 32'd0);
    idle();
    chk("self_drop_pulse", {31'd0, drop}, 32'd0);
`else
    chk("self_drop", {31'd0, drop}, 32'd0);
    chk("self_count", {27'd0, count}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 1);
`endif
    drive(1, 4'd1, 4'd1, 1'b0, 1'b1, 15'h0066, 0);
    req_valid = 1'b0;
    chk("bcast_count", {27'd0, count}, 32'd1);
    chk("bcast_data", data_out, 32'hFF110066);
    drive(0, 0, 0, 0, 0, 0, 1);
    popin = 1'b0;
    idle();
    chk("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
